// File: rtl/simple_480p_timing_if.sv
// Raster timing bundle from the 480p timing generator to the pixel
// source and TMDS encoder.
interface simple_480p_timing_if;
  logic [9:0] screen_x;
  logic [9:0] screen_y;
  logic       hsync;
  logic       vsync;
  logic       data_enable;
  logic       line_start;
  logic       frame_start;

  modport master (
    output screen_x, screen_y,
    output hsync, vsync,
    output data_enable,
    output line_start, frame_start
  );

  modport slave (
    input screen_x, screen_y,
    input hsync, vsync,
    input data_enable,
    input line_start, frame_start
  );
endinterface

// File: rtl/simple_480p_timing.sv
// Free-running 640x480@60 raster generator in the pixel clock domain.
// All decodes are registered from the next coordinate so they align with it.
module simple_480p_timing #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic clk_pix,
  input  logic rst_pix,
  simple_480p_timing_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
    $error("raster totals exceed 10-bit counters");
  end

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       h_wrap;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       de_nxt;

  always_comb begin
    h_wrap = (vid.screen_x == H_LAST);
    x_nxt  = h_wrap ? 10'd0 : vid.screen_x + 10'd1;
    y_nxt  = vid.screen_y;
    if (h_wrap) begin
      y_nxt = (vid.screen_y == V_LAST) ? 10'd0 : vid.screen_y + 10'd1;
    end
    hs_nxt = (x_nxt >= HS_BEG) && (x_nxt <= HS_END);
    vs_nxt = (y_nxt >= VS_BEG) && (y_nxt <= VS_END);
    de_nxt = (x_nxt < H_ACT) && (y_nxt < V_ACT);
  end

  always_ff @(posedge clk_pix or negedge rst_pix) begin
    if (!rst_pix) begin
      vid.screen_x    <= H_LAST;
      vid.screen_y    <= V_LAST;
      vid.hsync       <= !SYNC_ACTIVE;
      vid.vsync       <= !SYNC_ACTIVE;
      vid.data_enable <= 1'b0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end else begin
      vid.screen_x    <= x_nxt;
      vid.screen_y    <= y_nxt;
      vid.hsync       <= hs_nxt ? SYNC_ACTIVE : !SYNC_ACTIVE;
      vid.vsync       <= vs_nxt ? SYNC_ACTIVE : !SYNC_ACTIVE;
      vid.data_enable <= de_nxt;
      vid.line_start  <= (x_nxt == 10'd0);
      vid.frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
    end
  end

endmodule

// File: tb/tb_simple_480p_timing.sv
// Directed bench: full-size raster for reset and line timing, a
// shrunken raster for vertical timing, frame wrap and per-frame counts.
module tb_simple_480p_timing;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b0;
  int   total = 0;
  int   fails = 0;

  always #5 clk_pix = ~clk_pix;

  simple_480p_timing_if vm ();
  simple_480p_timing_if vs ();

  simple_480p_timing u_main (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .vid     (vm)
  );

  // 15 x 13 raster: sync x 10..12, sync y 8..9, 195 clocks per frame
  simple_480p_timing #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_ACTIVE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .SYNC_ACTIVE (1'b0)
  ) u_small (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .vid     (vs)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_main_rst(input string pfx);
    chk({pfx, "_x"}, 32'(vm.screen_x), 799);
    chk({pfx, "_y"}, 32'(vm.screen_y), 524);
    chk({pfx, "_hs"}, 32'(vm.hsync), 1);
    chk({pfx, "_vs"}, 32'(vm.vsync), 1);
    chk({pfx, "_de"}, 32'(vm.data_enable), 0);
    chk({pfx, "_ls"}, 32'(vm.line_start), 0);
    chk({pfx, "_fs"}, 32'(vm.frame_start), 0);
  endtask

  int de_cnt [2];
  int hs_cnt [2];
  int vs_cnt [2];
  int fs_at  [$];
  int over;

  initial begin
    repeat (2) @(negedge clk_pix);
    chk_main_rst("rst");
    chk("rst_small_x", 32'(vs.screen_x), 14);
    chk("rst_small_y", 32'(vs.screen_y), 12);

    rst_pix = 1'b1;
    @(negedge clk_pix);
    chk("first_x", 32'(vm.screen_x), 0);
    chk("first_y", 32'(vm.screen_y), 0);
    chk("first_de", 32'(vm.data_enable), 1);
    chk("first_ls", 32'(vm.line_start), 1);
    chk("first_fs", 32'(vm.frame_start), 1);
    chk("first_hs", 32'(vm.hsync), 1);

    for (int c = 1; c <= 800; c++) begin
      @(negedge clk_pix);
      case (c)
        1: chk("ls_drop", 32'(vm.line_start), 0);
        639: chk("de_639", 32'(vm.data_enable), 1);
        640: chk("de_640", 32'(vm.data_enable), 0);
        655: chk("hs_655", 32'(vm.hsync), 1);
        656: chk("hs_656", 32'(vm.hsync), 0);
        751: chk("hs_751", 32'(vm.hsync), 0);
        752: chk("hs_752", 32'(vm.hsync), 1);
        799: begin
          chk("end_x", 32'(vm.screen_x), 799);
          chk("end_y", 32'(vm.screen_y), 0);
        end
        800: begin
          chk("wrap_x", 32'(vm.screen_x), 0);
          chk("wrap_y", 32'(vm.screen_y), 1);
          chk("wrap_ls", 32'(vm.line_start), 1);
          chk("wrap_fs", 32'(vm.frame_start), 0);
        end
        default: ;
      endcase
    end

    repeat (300) @(negedge clk_pix);
    chk("mid_x", 32'(vm.screen_x), 300);
    chk("mid_y", 32'(vm.screen_y), 1);
    chk("mid_de", 32'(vm.data_enable), 1);
    #2 rst_pix = 1'b0;
    #1 chk_main_rst("async");
    @(negedge clk_pix);
    chk_main_rst("held");
    rst_pix = 1'b1;
    @(negedge clk_pix);
    chk("restart_x", 32'(vm.screen_x), 0);
    chk("restart_y", 32'(vm.screen_y), 0);
    chk("restart_fs", 32'(vm.frame_start), 1);

    over = 0;
    for (int f = 0; f < 2; f++) begin
      de_cnt[f] = 0;
      hs_cnt[f] = 0;
      vs_cnt[f] = 0;
    end
    for (int c = 0; c < 390; c++) begin
      if (c > 0) @(negedge clk_pix);
      if (vs.screen_x > 14 || vs.screen_y > 12) over++;
      if (vm.screen_x > 799 || vm.screen_y > 524) over++;
      if (vs.frame_start) fs_at.push_back(c);
      if (vs.data_enable) de_cnt[c / 195]++;
      if (!vs.hsync) hs_cnt[c / 195]++;
      if (!vs.vsync) vs_cnt[c / 195]++;
      case (c)
        9: chk("s_hs_9", 32'(vs.hsync), 1);
        10: chk("s_hs_10", 32'(vs.hsync), 0);
        12: chk("s_hs_12", 32'(vs.hsync), 0);
        13: chk("s_hs_13", 32'(vs.hsync), 1);
        82: chk("s_de_x7y5", 32'(vs.data_enable), 1);
        83: chk("s_de_x8y5", 32'(vs.data_enable), 0);
        90: chk("s_de_x0y6", 32'(vs.data_enable), 0);
        119: chk("s_vs_x14y7", 32'(vs.vsync), 1);
        120: chk("s_vs_x0y8", 32'(vs.vsync), 0);
        149: chk("s_vs_x14y9", 32'(vs.vsync), 0);
        150: chk("s_vs_x0y10", 32'(vs.vsync), 1);
        194: begin
          chk("s_last_x", 32'(vs.screen_x), 14);
          chk("s_last_y", 32'(vs.screen_y), 12);
          chk("s_last_fs", 32'(vs.frame_start), 0);
        end
        195: begin
          chk("s_wrap_x", 32'(vs.screen_x), 0);
          chk("s_wrap_y", 32'(vs.screen_y), 0);
          chk("s_wrap_fs", 32'(vs.frame_start), 1);
        end
        default: ;
      endcase
    end

    chk("range", 32'(over), 0);
    chk("fs_count", 32'(fs_at.size()), 2);
    if (fs_at.size() >= 2) begin
      chk("fs_period", 32'(fs_at[1] - fs_at[0]), 195);
    end
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("de_cnt_f%0d", f), 32'(de_cnt[f]), 48);
      chk($sformatf("hs_cnt_f%0d", f), 32'(hs_cnt[f]), 39);
      chk($sformatf("vs_cnt_f%0d", f), 32'(vs_cnt[f]), 30);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/simple_480p_timing.md
Name: simple_480p_timing

Overview:
- Free-running video timing generator for 640x480 at 60 Hz, clocked by the pixel clock (nominally 25.175 MHz).
- Produces the current raster coordinate, horizontal and vertical sync, and an active-video data enable.
- Sits between the pixel clock domain and the pixel source / TMDS encoder of the HDMI path.
- Runs continuously after reset; no handshake.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525
- SYNC_ACTIVE, 0, level of hsync/vsync while asserted (0 = negative polarity, the 480p standard)

Ports:
- clk_pix  in  1  pixel clock; all state changes on its rising edge
- rst_pix  in  1  asynchronous, active-low reset (0 = reset)
- screen_x  out  10  current horizontal position, 0..H_TOTAL-1
- screen_y  out  10  current vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE
- data_enable  out  1  high while (screen_x, screen_y) is inside the active area
- line_start  out  1  one-cycle pulse when screen_x == 0
- frame_start  out  1  one-cycle pulse when screen_x == 0 and screen_y == 0

Behaviour:
- Reset (rst_pix low, asynchronous):
  - screen_x = H_TOTAL-1 (799), screen_y = V_TOTAL-1 (524).
  - hsync = vsync = !SYNC_ACTIVE (1); data_enable = 0; line_start = frame_start = 0.
  - Held while rst_pix is low, whatever clk_pix does.
- First rising edge after rst_pix goes high: screen_x = 0, screen_y = 0, data_enable = 1, line_start = frame_start = 1.
- Horizontal counter:
  - Increments by 1 each clock.
  - At H_TOTAL-1 it wraps to 0 on the next edge.
- Vertical counter:
  - Increments by 1 on the same edge the horizontal counter wraps.
  - At V_TOTAL-1 it wraps to 0 on that edge.
  - Changes only on horizontal wrap.
- Default decodes:
  - hsync asserted iff 656 <= screen_x <= 751, i.e. H_ACTIVE+H_FRONT through H_ACTIVE+H_FRONT+H_SYNC-1.
  - vsync asserted iff 490 <= screen_y <= 491; it changes at screen_x == 0 of those lines.
  - data_enable = (screen_x < H_ACTIVE) and (screen_y < V_ACTIVE).
- Alignment and timing:
  - hsync, vsync, data_enable, line_start and frame_start are exact functions of the screen_x/screen_y values presented in the same cycle; zero relative latency.
  - Every output changes only on a rising clk_pix edge or on reset assertion; no glitches on outputs.
- Widths: 10-bit counters; parameters must keep H_TOTAL and V_TOTAL <= 1024.
- Reset mid-frame: outputs return immediately to the reset values; the sequence restarts at (0,0) on the first edge after release.
- Frame period: 420000 clocks, of which data_enable is high for exactly 307200.

Test Plan:
- Hold rst_pix low 1 cycle -> screen_x=799, screen_y=524, hsync=1, vsync=1, data_enable=0. Release -> next edge gives (0,0), data_enable=1, frame_start=1.
- Line 0 horizontal sweep:
  - data_enable high for x=0..639, low at x=640.
  - hsync falls at x=656 and rises at x=752.
  - screen_x goes 799 -> 0 with screen_y 0 -> 1; line_start pulses.
- Vertical timing:
  - data_enable stays low for all x on y=480..524.
  - vsync low exactly for y=490 and 491; high again at (0,492).
- Frame wrap: (799,524) -> (0,0) with frame_start=1. Second frame_start follows exactly 420000 clocks after the first.
- Long run of 1,000,000 clocks (~2.38 frames):
  - screen_x never exceeds 799 and screen_y never exceeds 524.
  - Per full frame: data_enable count is 307200, hsync-asserted count is 50400, vsync-asserted count is 1600.
- Reset mid-frame: assert rst_pix at (300,200) asynchronously -> outputs reach reset values without a clock edge. On release, the sequence restarts from (0,0).
